filter_arbiter: RTL and testbench

FILTER_ARBITER -- requirements
Module: filter_arbiter

---
 rtl/filter_arbiter.sv | 129 ++++++++++++
 tb/tb_filter_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// filter_arbiter: round-robin 2:1 sharing of a fixed-latency filter, with
// tag-based result routing. Rev 1.0
// ---------------------------------------------------------------------------
module filter_arbiter #(
  parameter int LATENCY = 2,
  parameter int CNTW    = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            io_enable,
  input  logic [15:0]     io_in0_data,
  input  logic            io_in0_valid,
  input  logic            io_in0_parity,
  output logic            io_in0_ready,
  input  logic [15:0]     io_in1_data,
  input  logic            io_in1_valid,
  input  logic            io_in1_parity,
  output logic            io_in1_ready,
  output logic [15:0]     io_f_x_data,
  output logic            io_f_x_valid,
  output logic            io_f_x_parity,
  input  logic [15:0]     io_f_y_data,
  input  logic            io_f_y_valid,
  input  logic            io_f_y_parity,
  output logic [15:0]     io_out0_data,
  output logic            io_out0_valid,
  output logic            io_out0_parity,
  output logic [15:0]     io_out1_data,
  output logic            io_out1_valid,
  output logic            io_out1_parity,
  output logic            io_busy,
  output logic            io_err,
  output logic [CNTW-1:0] io_cnt0,
  output logic [CNTW-1:0] io_cnt1
);

  logic               gnt_valid, gnt_id;
  logic               ptr_q, ptr_d;
  logic [LATENCY-1:0] vld_q, vld_d, id_q, id_d, ghost_q, ghost_d;
  logic               err_q, err_d, busy_q;
  logic [CNTW-1:0]    cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic               last_vld, last_id, last_ghost, route, mismatch;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = 1'b0;
    if (!reset && io_enable) begin
      if (io_in0_valid && io_in1_valid) begin
        gnt_valid = 1'b1;
        gnt_id    = ptr_q;
      end else if (io_in0_valid) begin
        gnt_valid = 1'b1;
        gnt_id    = 1'b0;
      end else if (io_in1_valid) begin
        gnt_valid = 1'b1;
        gnt_id    = 1'b1;
      end
    end
  end

  assign io_in0_ready  = gnt_valid && !gnt_id;
  assign io_in1_ready  = gnt_valid && gnt_id;
  assign io_f_x_valid  = gnt_valid;
  assign io_f_x_data   = io_in0_ready ? io_in0_data   : (io_in1_ready ? io_in1_data   : 16'h0000);
  assign io_f_x_parity = io_in0_ready ? io_in0_parity : (io_in1_ready ? io_in1_parity : 1'b0);

  assign ptr_d  = gnt_valid ? ~gnt_id : ptr_q;
  assign cnt0_d = io_in0_ready ? cnt0_q + CNTW'(1) : cnt0_q;
  assign cnt1_d = io_in1_ready ? cnt1_q + CNTW'(1) : cnt1_q;

  // Ghost tags remember beats discarded by reset so their late filter
  // outputs are swallowed instead of being routed or flagged as errors.
  always_comb begin
    vld_d      = '0;
    id_d       = '0;
    ghost_d    = '0;
    vld_d[0]   = gnt_valid;
    id_d[0]    = gnt_id;
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i]   = vld_q[i-1];
      id_d[i]    = id_q[i-1];
      ghost_d[i] = ghost_q[i-1] | (reset & vld_q[i-1]);
    end
  end

  assign last_vld   = vld_q[LATENCY-1];
  assign last_id    = id_q[LATENCY-1];
  assign last_ghost = ghost_q[LATENCY-1];
  assign route      = !reset && last_vld && io_f_y_valid;
  assign mismatch   = !reset && !last_ghost && (io_f_y_valid != last_vld);
  assign err_d      = err_q | mismatch;

  assign io_out0_valid  = route && !last_id;
  assign io_out1_valid  = route && last_id;
  assign io_out0_data   = io_out0_valid ? io_f_y_data   : 16'h0000;
  assign io_out0_parity = io_out0_valid ? io_f_y_parity : 1'b0;
  assign io_out1_data   = io_out1_valid ? io_f_y_data   : 16'h0000;
  assign io_out1_parity = io_out1_valid ? io_f_y_parity : 1'b0;

  always_ff @(posedge clk) begin
    ghost_q <= ghost_d;
    if (reset) begin
      ptr_q  <= 1'b0;
      vld_q  <= '0;
      id_q   <= '0;
      err_q  <= 1'b0;
      busy_q <= 1'b0;
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      vld_q  <= vld_d;
      id_q   <= id_d;
      err_q  <= err_d;
      busy_q <= |vld_d;
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign io_busy = busy_q;
  assign io_err  = err_q;
  assign io_cnt0 = cnt0_q;
  assign io_cnt1 = cnt1_q;

endmodule
`default_nettype wire

// File: tb/tb_filter_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_filter_arbiter: randomized and directed bench with an ideal filter stub,
// a reference model and a result scoreboard. Rev 1.0
// ---------------------------------------------------------------------------
module tb_filter_arbiter;
  localparam int LAT = 2;
  localparam int CW  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic inj = 1'b0;
  logic [15:0] d0 = '0, d1 = '0;
  logic v0 = 1'b0, v1 = 1'b0, p0 = 1'b0, p1 = 1'b0;
  logic rdy0, rdy1, fxv, fxp, fyv, fyp;
  logic [15:0] fxd, fyd, o0d, o1d;
  logic o0v, o0p, o1v, o1p, busy, err;
  logic [CW-1:0] cnt0, cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  filter_arbiter #(.LATENCY(LAT), .CNTW(CW)) dut (
    .clk(clk), .reset(rst), .io_enable(en),
    .io_in0_data(d0), .io_in0_valid(v0), .io_in0_parity(p0), .io_in0_ready(rdy0),
    .io_in1_data(d1), .io_in1_valid(v1), .io_in1_parity(p1), .io_in1_ready(rdy1),
    .io_f_x_data(fxd), .io_f_x_valid(fxv), .io_f_x_parity(fxp),
    .io_f_y_data(fyd), .io_f_y_valid(fyv), .io_f_y_parity(fyp),
    .io_out0_data(o0d), .io_out0_valid(o0v), .io_out0_parity(o0p),
    .io_out1_data(o1d), .io_out1_valid(o1v), .io_out1_parity(o1p),
    .io_busy(busy), .io_err(err), .io_cnt0(cnt0), .io_cnt1(cnt1)
  );

  function automatic logic [15:0] filt(input logic [15:0] x);
    return {x[7:0], x[15:8]} ^ 16'h5A5A;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Ideal filter stub: fixed LAT-cycle delay, never reset.
  logic [LAT-1:0] fv = '0;
  logic [15:0]    fd [LAT] = '{default: 16'h0};
  logic           fp [LAT] = '{default: 1'b0};
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) begin
      fv[i] <= fv[i-1];
      fd[i] <= fd[i-1];
      fp[i] <= fp[i-1];
    end
    fv[0] <= fxv;
    fd[0] <= filt(fxd);
    fp[0] <= ~fxp;
  end
  assign fyv = fv[LAT-1] | inj;
  assign fyd = fd[LAT-1];
  assign fyp = fp[LAT-1];

  // Reference model state
  typedef struct { bit id; logic [15:0] d; logic p; } res_t;
  res_t sb[$];
  int   gq[$], dq[$], tmp[$];
  int   cyc = 0;
  bit   ptr_m = 1'b0, err_m = 1'b0;
  int   cnt0_m = 0, cnt1_m = 0;
  bit   eg, eid, exp_last, ghost, busy_exp;
  res_t r;

  always @(negedge clk) begin
    tmp.delete();
    foreach (gq[i]) if (gq[i] + LAT >= cyc) tmp.push_back(gq[i]);
    gq = tmp;
    tmp.delete();
    foreach (dq[i]) if (dq[i] + LAT >= cyc) tmp.push_back(dq[i]);
    dq = tmp;
    exp_last = 1'b0;
    ghost    = 1'b0;
    foreach (gq[i]) if (gq[i] == cyc - LAT) exp_last = 1'b1;
    foreach (dq[i]) if (dq[i] == cyc - LAT) ghost = 1'b1;
    busy_exp = (gq.size() > 0);

    eg  = !rst && en && (v0 || v1);
    eid = (v0 && v1) ? ptr_m : !v0;

    chk("ready0", rdy0, eg && !eid);
    chk("ready1", rdy1, eg && eid);
    chk("fx_valid", fxv, eg);
    chk("fx_data", fxd, !eg ? 16'h0 : (eid ? d1 : d0));
    chk("fx_parity", fxp, !eg ? 1'b0 : (eid ? p1 : p0));
    chk("busy", busy, busy_exp);
    chk("err", err, err_m);
    chk("cnt0", cnt0, cnt0_m % (1 << CW));
    chk("cnt1", cnt1, cnt1_m % (1 << CW));
    chk("route", o0v | o1v, !rst && exp_last && fyv);

    if (rst) begin
      ptr_m = 1'b0; err_m = 1'b0; cnt0_m = 0; cnt1_m = 0;
      foreach (gq[i]) dq.push_back(gq[i]);
      gq.delete();
      sb.delete();
    end else begin
      if ((fyv != exp_last) && !ghost) err_m = 1'b1;
      if (eg) begin
        r.id = eid;
        r.d  = filt(eid ? d1 : d0);
        r.p  = ~(eid ? p1 : p0);
        sb.push_back(r);
        gq.push_back(cyc);
        ptr_m = ~eid;
        if (eid) cnt1_m++; else cnt0_m++;
      end
    end
    cyc++;
  end

  // Output monitor: pops the scoreboard whenever a result is presented.
  res_t m;
  always @(negedge clk) begin
    if (!rst) begin
      chk("both_out_valid", o0v & o1v, 1'b0);
      if (o0v || o1v) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected: got result %0h with empty scoreboard", o0v ? o0d : o1d);
        end else begin
          m = sb.pop_front();
          chk("out_id", o1v, m.id);
          chk("out_data", o1v ? o1d : o0d, m.d);
          chk("out_parity", o1v ? o1p : o0p, m.p);
        end
      end
      if (!o0v) chk("out0_idle", {o0p, o0d}, 17'h0);
      if (!o1v) chk("out1_idle", {o1p, o1d}, 17'h0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int c0s, c1s;

  initial begin
    repeat (3) tick();
    chk("rst_cnt0", cnt0, 0);
    chk("rst_busy", busy, 0);

    // Lone requester
    rst = 1'b0; en = 1'b1; v0 = 1'b1; d0 = 16'h1234; p0 = 1'b1;
    repeat (3) tick();
    v0 = 1'b0;
    chk("lone_cnt0", cnt0, 3);
    chk("lone_cnt1", cnt1, 0);
    repeat (LAT + 2) tick();

    // Contention straight after reset
    rst = 1'b1; tick();
    rst = 1'b0; v0 = 1'b1; v1 = 1'b1; d0 = 16'hA001; d1 = 16'hB002;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_ready0", rdy0, (i % 2) == 0);
      tick();
      d0 = d0 + 16'd1; d1 = d1 + 16'd1;
    end
    chk("rr_cnt0", cnt0, 2);
    chk("rr_cnt1", cnt1, 2);

    // Enable low with both requesters still valid
    en = 1'b0;
    c0s = int'(cnt0); c1s = int'(cnt1);
    repeat (LAT - 1) tick();
    chk("en_busy_hold", busy, 1);
    tick();
    chk("en_busy_fall", busy, 0);
    repeat (3) tick();
    chk("en_cnt0", cnt0, c0s);
    chk("en_cnt1", cnt1, c1s);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 79) == 0);
      en  = ($urandom_range(0, 4) != 0);
      v0  = $urandom_range(0, 1); v1 = $urandom_range(0, 1);
      d0  = 16'($urandom); d1 = 16'($urandom);
      p0  = $urandom_range(0, 1); p1 = $urandom_range(0, 1);
      tick();
    end
    rst = 1'b0; v0 = 1'b0; v1 = 1'b0;
    repeat (LAT + 2) tick();

    // Counter wrap on requester 1
    rst = 1'b1; tick();
    rst = 1'b0; en = 1'b1; v1 = 1'b1;
    for (int i = 0; i < 256; i++) begin
      d1 = 16'(i); tick();
    end
    v1 = 1'b0;
    chk("wrap_cnt1", cnt1, 0);
    chk("wrap_cnt0", cnt0, 0);
    repeat (LAT + 2) tick();

    // Reset mid-flight
    v0 = 1'b1; d0 = 16'hC0DE; tick();
    v0 = 1'b0; rst = 1'b1; tick();
    rst = 1'b0;
    repeat (LAT + 3) tick();
    chk("midrst_busy", busy, 0);
    chk("midrst_err", err, 0);

    // Unexpected filter output with an empty pipeline
    en = 1'b0;
    repeat (LAT + 2) tick();
    inj = 1'b1; tick();
    inj = 1'b0;
    chk("inject_err", err, 1);
    repeat (4) tick();
    chk("inject_err_sticky", err, 1);

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1);
  end

endmodule
`default_nettype wire
